// File: rtl/complex_incr_engine_if.sv
// rtl/complex_incr_engine_if.sv - command and status bus of the complex increment engine
interface complex_incr_engine_if #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 16
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [CH_W-1:0]         cmd_ch;
    logic                    cmd_type;
    logic                    cmd_clr;
    logic [NUM_CH-1:0]       busy;
    logic [NUM_CH-1:0]       done;
    logic [NUM_CH*WIDTH-1:0] ch_x;
    logic [NUM_CH*WIDTH-1:0] ch_y;

    modport master (
        output cmd_valid, cmd_ch, cmd_type, cmd_clr,
        input  cmd_ready, busy, done, ch_x, ch_y
    );

    modport slave (
        input  cmd_valid, cmd_ch, cmd_type, cmd_clr,
        output cmd_ready, busy, done, ch_x, ch_y
    );
endinterface

// File: rtl/complex_incr_engine.sv
// rtl/complex_incr_engine.sv - per-channel complex counters stepped REPEAT times, INTERVAL cycles apart; optional macro COMPLEX_INCR_SATURATE_EN
module complex_incr_engine #(
    parameter int NUM_CH   = 4,
    parameter int WIDTH    = 16,
    parameter int REPEAT   = 5,
    parameter int INTERVAL = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    complex_incr_engine_if.slave  bus
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;
    localparam int TMR_W = (INTERVAL > 2) ? $clog2(INTERVAL - 1) : 1;

    // Remaining increments after the first one of a run.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(REPEAT - 1);
    // WAIT lasts INTERVAL-1 cycles: loaded value plus the terminal zero cycle.
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'((INTERVAL >= 2) ? (INTERVAL - 2) : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] v);
`ifdef COMPLEX_INCR_SATURATE_EN
        step = (v == {WIDTH{1'b1}}) ? v : v + WIDTH'(1);
`else
        step = v + WIDTH'(1);
`endif
    endfunction

    logic [NUM_CH-1:0] idle_vec;
    logic [NUM_CH-1:0] busy_vec;
    logic [NUM_CH-1:0] done_vec;
    logic              ready;

    // A command is only accepted by the addressed channel, and only while it is idle.
    always_comb begin
        ready = 1'b0;
        for (int n = 0; n < NUM_CH; n++) begin
            if (bus.cmd_ch == CH_W'(n)) begin
                ready = idle_vec[n];
            end
        end
    end

    assign bus.cmd_ready = ready;
    assign bus.busy      = busy_vec;
    assign bus.done      = done_vec;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        state_t           state, state_nxt;
        logic [WIDTH-1:0] x, x_nxt;
        logic [WIDTH-1:0] y, y_nxt;
        logic             typ, typ_nxt;
        logic [CNT_W-1:0] cnt, cnt_nxt;
        logic [TMR_W-1:0] tmr, tmr_nxt;
        logic             done_q, done_nxt;
        logic             accept;

        assign accept = bus.cmd_valid && (bus.cmd_ch == CH_W'(n)) && (state == S_IDLE);

        // Channel state register; reset aborts any run without a done pulse.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state  <= S_IDLE;
                x      <= '0;
                y      <= '0;
                typ    <= 1'b0;
                cnt    <= '0;
                tmr    <= '0;
                done_q <= 1'b0;
            end else begin
                state  <= state_nxt;
                x      <= x_nxt;
                y      <= y_nxt;
                typ    <= typ_nxt;
                cnt    <= cnt_nxt;
                tmr    <= tmr_nxt;
                done_q <= done_nxt;
            end
        end

        // Next-state: accept in IDLE, increment in RUN, pace increments in WAIT.
        always_comb begin
            state_nxt = state;
            x_nxt     = x;
            y_nxt     = y;
            typ_nxt   = typ;
            cnt_nxt   = cnt;
            tmr_nxt   = tmr;
            done_nxt  = 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (bus.cmd_clr) begin
                            x_nxt = '0;
                            y_nxt = '0;
                        end else begin
                            typ_nxt   = bus.cmd_type;
                            cnt_nxt   = CNT_LOAD;
                            state_nxt = S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (typ) begin
                        y_nxt = step(y);
                    end else begin
                        x_nxt = step(x);
                    end
                    if (cnt == '0) begin
                        state_nxt = S_IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                        if (INTERVAL == 1) begin
                            state_nxt = S_RUN;
                        end else begin
                            tmr_nxt   = TMR_LOAD;
                            state_nxt = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (tmr == '0) begin
                        state_nxt = S_RUN;
                    end else begin
                        tmr_nxt = tmr - TMR_W'(1);
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end

        assign idle_vec[n]                  = (state == S_IDLE);
        assign busy_vec[n]                  = (state != S_IDLE);
        assign done_vec[n]                  = done_q;
        assign bus.ch_x[n*WIDTH +: WIDTH]   = x;
        assign bus.ch_y[n*WIDTH +: WIDTH]   = y;
    end
endmodule

// File: tb/tb_complex_incr_engine.sv
// tb/tb_complex_incr_engine.sv - directed table-driven bench for complex_incr_engine
module tb_complex_incr_engine;
    localparam int NUM_CH   = 4;
    localparam int WIDTH    = 8;
    localparam int REPEAT   = 5;
    localparam int INTERVAL = 10;
    localparam int LAT      = 1 + (REPEAT - 1) * INTERVAL;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    complex_incr_engine_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) bus ();

    complex_incr_engine #(
        .NUM_CH(NUM_CH), .WIDTH(WIDTH), .REPEAT(REPEAT), .INTERVAL(INTERVAL)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         ch;
        logic       typ;
        logic       clr;
        logic [7:0] ex;
        logic [7:0] ey;
    } vec_t;

    vec_t       tbl [6];
    logic [7:0] mx [NUM_CH];
    logic [7:0] my [NUM_CH];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NUM_CH*WIDTH-1:0] pack(input logic [7:0] v [NUM_CH]);
        logic [NUM_CH*WIDTH-1:0] r;
        for (int i = 0; i < NUM_CH; i++) r[i*WIDTH +: WIDTH] = v[i];
        return r;
    endfunction

    // Present a command at the falling edge, wait for ready, return 1ns after the accept edge.
    task automatic issue(input int ch, input logic typ, input logic clr);
        int n;
        n = 0;
        @(negedge clk);
        bus.cmd_ch    = 2'(ch);
        bus.cmd_type  = typ;
        bus.cmd_clr   = clr;
        bus.cmd_valid = 1'b1;
        #1;
        while (!bus.cmd_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            errors++;
            checks++;
            $display("FAIL accept_timeout: ch %0d never ready", ch);
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    // Count edges from the accept edge until done is seen for the channel.
    task automatic wait_done(input int ch, output int lat, output logic busy_first,
                             output logic busy_at_done);
        lat = 0;
        busy_first = 1'b0;
        busy_at_done = 1'b1;
        while (lat < 200) begin
            if (lat == 0) busy_first = bus.busy[ch];
            @(posedge clk);
            #1;
            lat++;
            if (bus.done[ch]) begin
                busy_at_done = bus.busy[ch];
                break;
            end
        end
    endtask

    initial begin
        int         lat;
        int         d0, d1, c;
        logic       bf, bd;
        logic       bad;
        logic [7:0] exp_wrap;

        tbl[0] = '{ch: 0, typ: 1'b0, clr: 1'b0, ex: 8'd5, ey: 8'd0};
        tbl[1] = '{ch: 0, typ: 1'b1, clr: 1'b0, ex: 8'd5, ey: 8'd5};
        tbl[2] = '{ch: 1, typ: 1'b1, clr: 1'b0, ex: 8'd0, ey: 8'd5};
        tbl[3] = '{ch: 0, typ: 1'b0, clr: 1'b1, ex: 8'd0, ey: 8'd0};
        tbl[4] = '{ch: 3, typ: 1'b1, clr: 1'b0, ex: 8'd0, ey: 8'd5};
        tbl[5] = '{ch: 1, typ: 1'b0, clr: 1'b0, ex: 8'd5, ey: 8'd5};
        for (int i = 0; i < NUM_CH; i++) begin
            mx[i] = '0;
            my[i] = '0;
        end

        bus.cmd_valid = 1'b0;
        bus.cmd_ch    = '0;
        bus.cmd_type  = 1'b0;
        bus.cmd_clr   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_x", bus.ch_x, '0);
        chk("reset_y", bus.ch_y, '0);
        chk("reset_busy", bus.busy, '0);
        chk("reset_done", bus.done, '0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            bus.cmd_ch = 2'(i);
            #1;
            chk($sformatf("reset_ready_ch%0d", i), bus.cmd_ready, 1'b1);
        end

        // Table: each command runs to completion before the next.
        for (int i = 0; i < 6; i++) begin
            issue(tbl[i].ch, tbl[i].typ, tbl[i].clr);
            if (tbl[i].clr) begin
                chk($sformatf("v%0d_clr_busy", i), bus.busy, '0);
                chk($sformatf("v%0d_clr_done", i), bus.done, '0);
            end else begin
                wait_done(tbl[i].ch, lat, bf, bd);
                chk($sformatf("v%0d_latency", i), lat, LAT);
                chk($sformatf("v%0d_busy_run", i), bf, 1'b1);
                chk($sformatf("v%0d_busy_at_done", i), bd, 1'b0);
                @(posedge clk);
                #1;
                chk($sformatf("v%0d_done_width", i), bus.done, '0);
            end
            mx[tbl[i].ch] = tbl[i].ex;
            my[tbl[i].ch] = tbl[i].ey;
            chk($sformatf("v%0d_x", i), bus.ch_x[tbl[i].ch*WIDTH +: WIDTH], tbl[i].ex);
            chk($sformatf("v%0d_y", i), bus.ch_y[tbl[i].ch*WIDTH +: WIDTH], tbl[i].ey);
            chk($sformatf("v%0d_all_x", i), bus.ch_x, pack(mx));
            chk($sformatf("v%0d_all_y", i), bus.ch_y, pack(my));
        end

        for (int i = 0; i < NUM_CH; i++) issue(i, 1'b0, 1'b1);
        chk("clear_all_x", bus.ch_x, '0);
        chk("clear_all_y", bus.ch_y, '0);

        // Two channels started one edge apart finish one edge apart.
        issue(0, 1'b0, 1'b0);
        bus.cmd_ch    = 2'd1;
        bus.cmd_type  = 1'b1;
        bus.cmd_clr   = 1'b0;
        bus.cmd_valid = 1'b1;
        d0 = -1;
        d1 = -1;
        c  = 0;
        #1;
        chk("conc_ch1_ready", bus.cmd_ready, 1'b1);
        while (c < 200 && (d0 < 0 || d1 < 0)) begin
            @(posedge clk);
            #1;
            c++;
            bus.cmd_valid = 1'b0;
            if (bus.done[0] && d0 < 0) d0 = c;
            if (bus.done[1] && d1 < 0) d1 = c;
        end
        chk("conc_done0", d0, LAT);
        chk("conc_done1", d1, LAT + 1);
        @(posedge clk);
        #1;
        chk("conc_x", bus.ch_x, 32'h0000_0005);
        chk("conc_y", bus.ch_y, 32'h0000_0500);

        // Second run to a busy channel stalls until the done cycle.
        issue(2, 1'b0, 1'b0);
        bus.cmd_ch    = 2'd2;
        bus.cmd_type  = 1'b0;
        bus.cmd_valid = 1'b1;
        c   = -1;
        bad = 1'b0;
        while (c < 200) begin
            @(negedge clk);
            c++;
            if (bus.cmd_ready !== bus.done[2]) bad = 1'b1;
            if (bus.cmd_ready) break;
        end
        chk("busy_ready_tracks_done", bad, 1'b0);
        chk("busy_accept_cycle", c, LAT);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        wait_done(2, lat, bf, bd);
        chk("busy_second_latency", lat, LAT);
        chk("busy_x2", bus.ch_x[2*WIDTH +: WIDTH], 8'd10);

        // 51 runs reach all-ones, the next run wraps or saturates.
        for (int i = 0; i < 51; i++) begin
            issue(3, 1'b0, 1'b0);
            wait_done(3, lat, bf, bd);
        end
        chk("wrap_x3_full", bus.ch_x[3*WIDTH +: WIDTH], 8'd255);
        issue(3, 1'b0, 1'b0);
        wait_done(3, lat, bf, bd);
        chk("wrap_done_latency", lat, LAT);
`ifdef COMPLEX_INCR_SATURATE_EN
        exp_wrap = 8'd255;
`else
        exp_wrap = 8'd4;
`endif
        chk("wrap_x3", bus.ch_x[3*WIDTH +: WIDTH], exp_wrap);
        chk("wrap_y3", bus.ch_y[3*WIDTH +: WIDTH], 8'd0);

        // cmd_type toggling after acceptance must not steer the run.
        issue(0, 1'b0, 1'b1);
        issue(0, 1'b0, 1'b0);
        lat = 0;
        while (lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            bus.cmd_type = ~bus.cmd_type;
            if (bus.done[0]) break;
        end
        chk("latch_latency", lat, LAT);
        chk("latch_x0", bus.ch_x[7:0], 8'd5);
        chk("latch_y0", bus.ch_y[7:0], 8'd0);
        issue(0, 1'b1, 1'b1);
        chk("clear_x0", bus.ch_x[7:0], 8'd0);
        chk("clear_y0", bus.ch_y[7:0], 8'd0);
        chk("clear_busy0", bus.busy[0], 1'b0);
        @(posedge clk);
        #1;
        chk("clear_no_done", bus.done, '0);

        // Reset during WAIT aborts the run silently.
        issue(1, 1'b1, 1'b0);
        repeat (15) @(posedge clk);
        #1;
        chk("rst_pre_busy1", bus.busy[1], 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_x", bus.ch_x, '0);
        chk("rst_y", bus.ch_y, '0);
        chk("rst_busy", bus.busy, '0);
        chk("rst_done", bus.done, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (bus.done !== '0) bad = 1'b1;
        end
        chk("rst_no_done", bad, 1'b0);
        for (int i = 0; i < NUM_CH; i++) begin
            bus.cmd_ch = 2'(i);
            #1;
            chk($sformatf("rst_ready_ch%0d", i), bus.cmd_ready, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
